// File: rtl/sync_word_demod.sv
// Frame-sync demodulator: hunts for a sync word within a bit-error tolerance, confirms frame-spaced
// repeats, then flywheels through missed syncs while passing payload words. Optional SYNC_DEMOD_ERRCNT_EN.
module sync_word_demod #(
    parameter int WIDTH       = 16,
    parameter int FRAME_LEN   = 8,
    parameter int MAX_ERR     = 1,
    parameter int CONFIRM_CNT = 2,
    parameter int MISS_LIMIT  = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic [WIDTH-1:0] sync_word,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_sof,
    output logic             locked
`ifdef SYNC_DEMOD_ERRCNT_EN
    ,
    output logic [15:0]      err_count
`endif
);

    localparam int PW   = $clog2(FRAME_LEN);
    localparam int CW   = $clog2(CONFIRM_CNT + 1);
    localparam int MW   = $clog2(MISS_LIMIT + 1);
    localparam int POPW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {HUNT, CONFIRM, LOCKED} state_t;

    state_t          r_state;
    logic [PW-1:0]   r_pos;
    logic [CW-1:0]   r_conf;
    logic [MW-1:0]   r_miss;
    logic [1:0]      r_rstSync;

    logic            w_rst_n;
    logic [WIDTH-1:0] w_diff;
    logic [POPW-1:0] w_pop;
    logic            w_match;
    logic            w_slot;
    logic [PW-1:0]   w_posNext;
    logic [CW-1:0]   w_confNext;
    logic [MW-1:0]   w_missNext;
    logic            w_enterLock;

    // Assertion reaches every flop at once; release is retimed onto clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rstSync <= 2'b00;
        else        r_rstSync <= {r_rstSync[0], 1'b1};
    end
    assign w_rst_n = r_rstSync[1];

    always_comb begin
        w_diff = in_data ^ sync_word;
        w_pop  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_pop = w_pop + POPW'(w_diff[i]);
        end
    end

    assign w_match     = (int'(w_pop) <= MAX_ERR);
    assign w_slot      = (r_pos == '0);
    assign w_posNext   = (r_pos == PW'(FRAME_LEN - 1)) ? '0 : r_pos + 1'b1;
    assign w_confNext  = r_conf + 1'b1;
    assign w_missNext  = r_miss + 1'b1;
    assign w_enterLock = in_valid && w_match &&
                         (((r_state == HUNT) && (CONFIRM_CNT == 1)) ||
                          ((r_state == CONFIRM) && w_slot && (int'(w_confNext) >= CONFIRM_CNT)));

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state   <= HUNT;
            r_pos     <= '0;
            r_conf    <= '0;
            r_miss    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sof   <= 1'b0;
            locked    <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (in_valid) begin
                r_pos   <= w_posNext;
                out_sof <= 1'b0;
                case (r_state)
                    HUNT: begin
                        if (w_match) begin
                            r_pos  <= PW'(1);
                            r_conf <= CW'(1);
                            r_miss <= '0;
                            if (w_enterLock) begin
                                r_state <= LOCKED;
                                locked  <= 1'b1;
                            end else begin
                                r_state <= CONFIRM;
                            end
                        end else begin
                            r_pos <= '0;
                        end
                    end
                    CONFIRM: begin
                        if (w_slot) begin
                            if (w_match) begin
                                r_conf <= w_confNext;
                                if (w_enterLock) begin
                                    r_state <= LOCKED;
                                    r_miss  <= '0;
                                    locked  <= 1'b1;
                                end
                            end else begin
                                r_state <= HUNT;
                                r_pos   <= '0;
                                r_conf  <= '0;
                            end
                        end
                    end
                    LOCKED: begin
                        if (w_slot) begin
                            // A missed sync below the limit still occupies the sync slot (flywheel).
                            if (w_match) begin
                                r_miss <= '0;
                            end else if (int'(w_missNext) >= MISS_LIMIT) begin
                                r_state <= HUNT;
                                r_pos   <= '0;
                                r_conf  <= '0;
                                r_miss  <= '0;
                                locked  <= 1'b0;
                            end else begin
                                r_miss <= w_missNext;
                            end
                        end else begin
                            out_valid <= 1'b1;
                            out_data  <= in_data;
                            out_sof   <= (r_pos == PW'(1));
                        end
                    end
                    default: r_state <= HUNT;
                endcase
            end
        end
    end

`ifdef SYNC_DEMOD_ERRCNT_EN
    logic        w_lockedSlot;
    logic [16:0] w_errSum;

    assign w_lockedSlot = in_valid && (r_state == LOCKED) && w_slot;
    assign w_errSum     = {1'b0, err_count} + 17'(w_pop);

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n)          err_count <= '0;
        else if (w_enterLock)  err_count <= '0;
        else if (w_lockedSlot) err_count <= w_errSum[16] ? 16'hFFFF : w_errSum[15:0];
    end
`endif

endmodule

// File: tb/tb_sync_word_demod.sv
// Directed bench for sync_word_demod (FRAME_LEN=4, CONFIRM_CNT=2, MISS_LIMIT=2, sync 16'hFFFF).
// Define SYNC_DEMOD_ERRCNT_EN to also check err_count.
module tb_sync_word_demod;

    logic        clk;
    logic        rst_n;
    logic        inValid;
    logic [15:0] inData;
    logic [15:0] syncWord;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_sof;
    logic        locked;
`ifdef SYNC_DEMOD_ERRCNT_EN
    logic [15:0] err_count;
`endif

    int checks = 0;
    int errors = 0;

    sync_word_demod #(
        .WIDTH(16), .FRAME_LEN(4), .MAX_ERR(1), .CONFIRM_CNT(2), .MISS_LIMIT(2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (inValid),
        .in_data   (inData),
        .sync_word (syncWord),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sof   (out_sof),
        .locked    (locked)
`ifdef SYNC_DEMOD_ERRCNT_EN
        ,
        .err_count (err_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic v, input logic [15:0] d);
        @(negedge clk);
        inValid = v;
        inData  = d;
        @(posedge clk);
        #1;
        inValid = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic expOv, input logic [15:0] expData,
                               input logic expSof, input logic expLk);
        checks++;
        if (expOv) begin
            assert ({out_valid, out_sof, locked, out_data} === {expOv, expSof, expLk, expData}) else begin
                errors++;
                $error("[TB] FAIL %s observed ov=%0b sof=%0b lk=%0b data=%h expected ov=%0b sof=%0b lk=%0b data=%h",
                       tag, out_valid, out_sof, locked, out_data, expOv, expSof, expLk, expData);
            end
        end else begin
            assert ({out_valid, locked} === {1'b0, expLk}) else begin
                errors++;
                $error("[TB] FAIL %s observed ov=%0b lk=%0b expected ov=0 lk=%0b",
                       tag, out_valid, locked, expLk);
            end
        end
    endtask

    task automatic checkReset(input string tag);
        checks++;
        assert ({out_valid, out_sof, locked, out_data} === 19'd0) else begin
            errors++;
            $error("[TB] FAIL %s observed ov=%0b sof=%0b lk=%0b data=%h expected all zero",
                   tag, out_valid, out_sof, locked, out_data);
        end
    endtask

`ifdef SYNC_DEMOD_ERRCNT_EN
    task automatic checkErr(input string tag, input logic [15:0] expErr);
        checks++;
        assert (err_count === expErr) else begin
            errors++;
            $error("[TB] FAIL %s observed err_count=%0d expected %0d", tag, err_count, expErr);
        end
    endtask
`endif

    // One frame: sync slot then three payload words base+1..base+3, optionally with idle gaps.
    task automatic frame(input string tag, input logic [15:0] syncIn, input logic [15:0] base,
                         input logic lkBefore, input logic lkAfter, input logic outPay, input logic gap);
        if (gap) begin
            applyStimulus(1'b0, 16'hDEAD);
            checkOutput($sformatf("%s gap0", tag), 1'b0, 16'h0, 1'b0, lkBefore);
        end
        applyStimulus(1'b1, syncIn);
        checkOutput($sformatf("%s sync", tag), 1'b0, 16'h0, 1'b0, lkAfter);
        for (int i = 1; i <= 3; i++) begin
            if (gap) begin
                applyStimulus(1'b0, 16'hBEEF);
                checkOutput($sformatf("%s gap%0d", tag, i), 1'b0, 16'h0, 1'b0, lkAfter);
                if (outPay && i > 1) begin
                    checks++;
                    assert (out_data === base + 16'(i - 1)) else begin
                        errors++;
                        $error("[TB] FAIL %s hold%0d observed data=%h expected %h",
                               tag, i, out_data, base + 16'(i - 1));
                    end
                end
            end
            applyStimulus(1'b1, base + 16'(i));
            checkOutput($sformatf("%s word%0d", tag, i), outPay, base + 16'(i), (i == 1), lkAfter);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        inValid  = 1'b0;
        inData   = 16'h0;
        syncWord = 16'hFFFF;
        repeat (3) @(posedge clk);
        #1;
        checkReset("reset");
`ifdef SYNC_DEMOD_ERRCNT_EN
        checkErr("reset err", 16'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);

        frame("acq1", 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        frame("acq2", 16'hFFFF, 16'h0010, 1'b0, 1'b1, 1'b1, 1'b0);

        frame("fly1", 16'h0000, 16'h0020, 1'b1, 1'b1, 1'b1, 1'b0);
        frame("fly2", 16'h0000, 16'h0030, 1'b1, 1'b0, 1'b0, 1'b0);

        frame("tol1", 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        frame("tol2", 16'hFFFE, 16'h0040, 1'b0, 1'b1, 1'b1, 1'b0);
`ifdef SYNC_DEMOD_ERRCNT_EN
        checkErr("err entry", 16'd0);
`endif
        frame("err1", 16'hFFFE, 16'h0050, 1'b1, 1'b1, 1'b1, 1'b0);
        frame("err2", 16'hFFFF, 16'h0060, 1'b1, 1'b1, 1'b1, 1'b0);
        frame("err3", 16'hFFFE, 16'h0070, 1'b1, 1'b1, 1'b1, 1'b0);
`ifdef SYNC_DEMOD_ERRCNT_EN
        checkErr("err accum", 16'd2);
`endif
        frame("drop1", 16'h0000, 16'h0080, 1'b1, 1'b1, 1'b1, 1'b0);
        frame("drop2", 16'h0000, 16'h0090, 1'b1, 1'b0, 1'b0, 1'b0);

        frame("tol3", 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'hFFFC);
        checkOutput("tol FFFC", 1'b0, 16'h0, 1'b0, 1'b0);

        frame("stall1", 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
        frame("stall2", 16'hFFFF, 16'h0010, 1'b0, 1'b1, 1'b1, 1'b1);

        applyStimulus(1'b1, 16'hFFFF);
        checkOutput("rst slot", 1'b0, 16'h0, 1'b0, 1'b1);
        applyStimulus(1'b1, 16'h00A1);
        checkOutput("rst pay", 1'b1, 16'h00A1, 1'b1, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkReset("async reset");
`ifdef SYNC_DEMOD_ERRCNT_EN
        checkErr("async reset err", 16'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        applyStimulus(1'b1, 16'h00A2);
        checkOutput("post rst", 1'b0, 16'h0, 1'b0, 1'b0);
        frame("relock1", 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        frame("relock2", 16'hFFFF, 16'h00B0, 1'b0, 1'b1, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sync_word_demod.md
SYNC_WORD_DEMOD -- requirements
Module: sync_word_demod

Interface
REQ-001 Parameter WIDTH, default 16, sample word width in bits (>=2).
REQ-002 Parameter FRAME_LEN, default 8, words per frame including the sync word (>=2).
REQ-003 Parameter MAX_ERR, default 1, maximum bit mismatches for a sync match (<WIDTH).
REQ-004 Parameter CONFIRM_CNT, default 2, consecutive frame-spaced matches needed to lock (>=1).
REQ-005 Parameter MISS_LIMIT, default 3, consecutive missed syncs that drop lock (>=1).
REQ-006 One clock; reset is asynchronous and active-low: clk  in  1  rising-edge clock.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 in_valid  in  1  in_data qualifier, one word per cycle when high.
REQ-009 in_data  in  WIDTH  input sample word.
REQ-010 sync_word  in  WIDTH  sync pattern, sampled every cycle.
REQ-011 out_valid  out  1  out_data holds a payload word this cycle.
REQ-012 out_data  out  WIDTH  registered payload word.
REQ-013 out_sof  out  1  first payload word of a frame, valid with out_valid.
REQ-014 locked  out  1  high while in LOCKED.

Function
REQ-015 match SHALL be popcount(in_data XOR sync_word) <= MAX_ERR, evaluated only when in_valid=1.
REQ-016 States: HUNT, CONFIRM, LOCKED; counters pos (0..FRAME_LEN-1), conf, miss; all advance only on in_valid=1.
REQ-017 With in_valid=0, state, counters and outputs (other than out_valid=0) SHALL hold.
REQ-018 HUNT: match -> pos=1, conf=1, go to CONFIRM, or directly to LOCKED if CONFIRM_CNT=1; non-match stays in HUNT.
REQ-019 Every valid word SHALL increment pos, wrapping FRAME_LEN-1 -> 0; pos=0 marks the expected sync slot.
REQ-020 CONFIRM, pos=0: match -> conf+1, go to LOCKED when conf reaches CONFIRM_CNT; non-match -> HUNT, counters cleared.
REQ-021 Payload words in HUNT and CONFIRM SHALL NOT be output.
REQ-022 LOCKED, pos=0: match clears miss; non-match increments miss; miss reaching MISS_LIMIT -> HUNT, else slot still treated as sync (flywheel).
REQ-023 LOCKED, pos 1..FRAME_LEN-1: out_valid=1 and out_data=in_data one cycle later; out_sof=1 when pos=1.
REQ-024 Latency SHALL be exactly one clock from in_data sample to out_data; no backpressure.
REQ-025 On the word that drops lock, no payload output; HUNT re-evaluates from the next valid word.
REQ-026 locked SHALL be registered, rising the cycle after the confirming sync and falling the cycle after the final miss.

Reset
REQ-027 rst_n=0 SHALL immediately force HUNT, pos=conf=miss=0, out_valid=0, out_sof=0, out_data=0, locked=0.
REQ-028 Reset mid-frame SHALL discard all frame context; reacquisition needs CONFIRM_CNT fresh matches.
REQ-029 Deassertion SHALL be synchronised so first activity is on a clk edge after rst_n rises.

Configuration
REQ-030 Macro SYNC_DEMOD_ERRCNT_EN defined: output err_count (16 bits) accumulates popcount mismatches of every LOCKED sync slot, saturating at 16'hFFFF, cleared on entry to LOCKED and on reset.
REQ-031 Macro undefined: err_count port and its logic SHALL be absent; all other behaviour identical.

Verification (WIDTH=16, FRAME_LEN=4, MAX_ERR=1, CONFIRM_CNT=2, MISS_LIMIT=2, sync_word=16'hFFFF)
REQ-032 Acquire: FFFF,0001,0002,0003,FFFF,0011,0012,0013 -> locked high after 2nd FFFF; outputs 0011(sof),0012,0013 each one cycle late.
REQ-033 Tolerance: confirming sync 16'hFFFE -> lock; 16'hFFFC -> back to HUNT, locked stays 0.
REQ-034 Flywheel: locked, one sync slot 16'h0000 -> stays locked, payload output; second consecutive 16'h0000 -> locked falls, no further payload.
REQ-035 Stall: same stream as REQ-032 with in_valid low every other cycle -> identical output sequence, out_valid only after valid inputs.
REQ-036 Reset: rst_n low mid-payload while locked -> all outputs 0 immediately; re-lock needs two frame-spaced matches.
REQ-037 SYNC_DEMOD_ERRCNT_EN: locked sync slots 16'hFFFE then 16'hFFFF then 16'hFFFE -> err_count=2.
